// File: rtl/mips_defs.sv
// Shared definitions for the multi-cycle MIPS controller.
// Holds the opcode/func constants, FSM state encodings, datapath select
// codes (alu_ctrl, pc_src, wd_sel, reg_dst, ext_op) and the instruction
// decoder used by the controller.
package mips_defs;

  // Primary opcodes, instruction [31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type function codes, instruction [5:0]
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  // alu_ctrl codes (zero-extended to the port width in the controller)
  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd3;
  localparam logic [3:0] ALU_LUI = 4'd4;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_MEM  = 2'd1;
  localparam logic [1:0] WD_PC4  = 2'd2;
  localparam logic [1:0] WD_HILO = 2'd3;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  localparam logic [1:0] EXT_SIGN  = 2'd0;
  localparam logic [1:0] EXT_ZERO  = 2'd1;
  localparam logic [1:0] EXT_UPPER = 2'd2;

  // Countdown width: covers MD_LATENCY up to 31
  localparam int MD_CNT_W = 5;

  typedef enum logic [4:0] {
    I_NOP, I_ADDU, I_SUBU, I_JR, I_MULT, I_MULTU, I_DIV, I_DIVU,
    I_MFHI, I_MFLO, I_LW, I_SW, I_BEQ, I_ORI, I_LUI, I_J, I_JAL
  } instr_e;

  // Anything not recognised collapses to I_NOP.
  function automatic instr_e decode_instr(input logic [5:0] opcode,
                                          input logic [5:0] func);
    instr_e i;
    i = I_NOP;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          FN_ADDU:  i = I_ADDU;
          FN_SUBU:  i = I_SUBU;
          FN_JR:    i = I_JR;
          FN_MULT:  i = I_MULT;
          FN_MULTU: i = I_MULTU;
          FN_DIV:   i = I_DIV;
          FN_DIVU:  i = I_DIVU;
          FN_MFHI:  i = I_MFHI;
          FN_MFLO:  i = I_MFLO;
          default:  i = I_NOP;
        endcase
      end
      OP_LW:   i = I_LW;
      OP_SW:   i = I_SW;
      OP_BEQ:  i = I_BEQ;
      OP_ORI:  i = I_ORI;
      OP_LUI:  i = I_LUI;
      OP_J:    i = I_J;
      OP_JAL:  i = I_JAL;
      default: i = I_NOP;
    endcase
    return i;
  endfunction

endpackage

// File: rtl/md_counter.sv
// Mult/div busy countdown.
// Loads LATENCY on load, then counts down by one per cycle until zero,
// regardless of what the controller FSM is doing.
// Ports:
//   clk     - clock, rising edge
//   reset_n - asynchronous active-low reset, clears the count
//   load    - load LATENCY into the countdown (takes priority)
//   busy    - high while the countdown is nonzero
module md_counter #(
  parameter int LATENCY = 5,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  output logic busy
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(LATENCY);
    end else if (count != '0) begin
      // Stops at zero, never wraps
      count <= count - CNT_W'(1);
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS subset controller.
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) with jumps finishing in DECODE,
// beq and mult/div finishing in EXEC. mfhi/mflo and a second mult/div wait
// in EXEC while the mult/div unit is still counting down.
// Ports:
//   clk, reset_n        - clock and asynchronous active-low reset
//   opcode, func, zero  - IR fields and ALU equal flag
//   pc_we, ir_we, reg_we, mem_we       - write enables
//   wd_sel, reg_dst, alu_src, alu_ctrl, ext_op, pc_src - datapath selects
//   md_start, md_sign   - mult/div start pulse and signedness
//   hilo_sel            - 0 LO, 1 HI for mfhi/mflo
//   busy                - mult/div countdown nonzero
//   state               - current FSM state (debug)
module multi_cycle_ctrl
  import mips_defs::*;
#(
  parameter int MD_LATENCY = 5,
  parameter int ALUCTRL_W  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [5:0]           opcode,
  input  logic [5:0]           func,
  input  logic                 zero,
  output logic                 pc_we,
  output logic                 ir_we,
  output logic                 reg_we,
  output logic                 mem_we,
  output logic [1:0]           wd_sel,
  output logic [1:0]           reg_dst,
  output logic                 alu_src,
  output logic [ALUCTRL_W-1:0] alu_ctrl,
  output logic [1:0]           ext_op,
  output logic [1:0]           pc_src,
  output logic                 md_start,
  output logic                 md_sign,
  output logic                 hilo_sel,
  output logic                 busy,
  output logic [2:0]           state
);

  state_e     cur_state;
  state_e     nxt_state;
  instr_e     instr;
  logic [3:0] alu_code;

  assign instr    = decode_instr(opcode, func);
  assign state    = cur_state;
  assign alu_ctrl = ALUCTRL_W'(alu_code);

  md_counter #(
    .LATENCY (MD_LATENCY),
    .CNT_W   (MD_CNT_W)
  ) u_md_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (md_start),
    .busy    (busy)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_state <= S_FETCH;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    reg_we    = 1'b0;
    mem_we    = 1'b0;
    wd_sel    = WD_ALU;
    reg_dst   = RD_RT;
    alu_src   = 1'b0;
    alu_code  = ALU_NOP;
    ext_op    = EXT_SIGN;
    pc_src    = PC_PLUS4;
    md_start  = 1'b0;
    md_sign   = 1'b0;
    hilo_sel  = 1'b0;

    case (cur_state)
      S_FETCH: begin
        ir_we     = 1'b1;
        pc_we     = 1'b1;
        pc_src    = PC_PLUS4;
        nxt_state = S_DECODE;
      end

      S_DECODE: begin
        case (instr)
          I_J: begin
            pc_we     = 1'b1;
            pc_src    = PC_JUMP;
            nxt_state = S_FETCH;
          end
          I_JAL: begin
            pc_we     = 1'b1;
            pc_src    = PC_JUMP;
            reg_we    = 1'b1;
            reg_dst   = RD_RA;
            wd_sel    = WD_PC4;
            nxt_state = S_FETCH;
          end
          I_JR: begin
            pc_we     = 1'b1;
            pc_src    = PC_RS;
            nxt_state = S_FETCH;
          end
          I_NOP:   nxt_state = S_FETCH;
          default: nxt_state = S_EXEC;
        endcase
      end

      S_EXEC: begin
        case (instr)
          I_ADDU: begin
            alu_code  = ALU_ADD;
            nxt_state = S_WB;
          end
          I_SUBU: begin
            alu_code  = ALU_SUB;
            nxt_state = S_WB;
          end
          I_ORI: begin
            alu_code  = ALU_OR;
            alu_src   = 1'b1;
            ext_op    = EXT_ZERO;
            nxt_state = S_WB;
          end
          I_LUI: begin
            alu_code  = ALU_LUI;
            alu_src   = 1'b1;
            ext_op    = EXT_UPPER;
            nxt_state = S_WB;
          end
          I_LW, I_SW: begin
            alu_code  = ALU_ADD;
            alu_src   = 1'b1;
            ext_op    = EXT_SIGN;
            nxt_state = S_MEM;
          end
          I_BEQ: begin
            alu_code  = ALU_SUB;
            pc_src    = PC_BRANCH;
            pc_we     = zero;
            nxt_state = S_FETCH;
          end
          // HI/LO are not valid until the countdown expires: stall here
          I_MFHI, I_MFLO: begin
            if (!busy) nxt_state = S_WB;
          end
          // A new mult/div must not restart a unit still in flight
          I_MULT, I_MULTU, I_DIV, I_DIVU: begin
            if (!busy) begin
              md_start  = 1'b1;
              md_sign   = (instr == I_MULT) || (instr == I_DIV);
              nxt_state = S_FETCH;
            end
          end
          default: nxt_state = S_FETCH;
        endcase
      end

      S_MEM: begin
        if (instr == I_SW) begin
          mem_we    = 1'b1;
          nxt_state = S_FETCH;
        end else begin
          nxt_state = S_WB;
        end
      end

      S_WB: begin
        reg_we    = 1'b1;
        nxt_state = S_FETCH;
        case (instr)
          I_LW: begin
            reg_dst = RD_RT;
            wd_sel  = WD_MEM;
          end
          I_ORI, I_LUI: reg_dst = RD_RT;
          I_MFHI: begin
            reg_dst  = RD_RD;
            wd_sel   = WD_HILO;
            hilo_sel = 1'b1;
          end
          I_MFLO: begin
            reg_dst = RD_RD;
            wd_sel  = WD_HILO;
          end
          default: reg_dst = RD_RD;
        endcase
      end

      default: nxt_state = S_FETCH;
    endcase
  end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have parameter MD_LATENCY, default 5, giving the busy cycles per mult/div (legal range 1..31).
REQ-002 SHALL have parameter ALUCTRL_W, default 4, giving the alu_ctrl width (at least 4).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 SHALL have port opcode, input, 6 bits, instruction [31:26] from the IR.
REQ-006 SHALL have port func, input, 6 bits, instruction [5:0] from the IR.
REQ-007 SHALL have port zero, input, 1 bit, ALU equal flag for beq.
REQ-008 SHALL have port pc_we, output, 1 bit, PC write enable.
REQ-009 SHALL have port ir_we, output, 1 bit, IR load enable.
REQ-010 SHALL have port reg_we, output, 1 bit, register-file write enable.
REQ-011 SHALL have port mem_we, output, 1 bit, data-memory write enable.
REQ-012 SHALL have port wd_sel, output, 2 bits, write-data source: 0 ALU, 1 MEM, 2 PC+4, 3 HI/LO.
REQ-013 SHALL have port reg_dst, output, 2 bits, write-register select: 0 rt, 1 rd, 2 $31.
REQ-014 SHALL have port alu_src, output, 1 bit: 0 rt, 1 extended immediate.
REQ-015 SHALL have port alu_ctrl, output, ALUCTRL_W bits: 0 nop, 1 or, 2 add, 3 sub, 4 lui.
REQ-016 SHALL have port ext_op, output, 2 bits: 0 sign, 1 zero, 2 upper.
REQ-017 SHALL have port pc_src, output, 2 bits: 0 PC+4, 1 branch target, 2 jump target, 3 rs.
REQ-018 SHALL have port md_start, output, 1 bit, one-cycle pulse starting the mult/div unit.
REQ-019 SHALL have port md_sign, output, 1 bit, the signedness of the mult/div; held with md_start.
REQ-020 SHALL have port hilo_sel, output, 1 bit: 0 LO, 1 HI (mfhi/mflo).
REQ-021 SHALL have port busy, output, 1 bit, high while the mult/div countdown is nonzero.
REQ-022 SHALL have port state, output, 3 bits, current FSM state for debug.

Function
REQ-023 SHALL decode addu, subu, jr, mult, multu, div, divu, mfhi, mflo, lw, sw, beq, ori, lui, j and jal; any other opcode/func is a NOP.
REQ-024 SHALL implement the states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
REQ-025 SHALL, in FETCH, assert ir_we=1, pc_we=1, pc_src=0, then go to DECODE.
REQ-026 SHALL, in DECODE, handle j as pc_we=1, pc_src=2, then FETCH.
REQ-027 SHALL, in DECODE, handle jal as pc_we=1, pc_src=2, reg_we=1, reg_dst=2, wd_sel=2, then FETCH.
REQ-028 SHALL, in DECODE, handle jr as pc_we=1, pc_src=3, then FETCH.
REQ-029 SHALL, in DECODE, handle a NOP as going to FETCH; all other instructions go to EXEC.
REQ-030 SHALL, in EXEC, drive alu_ctrl, alu_src and ext_op per instruction: addu add/0, subu sub/0, ori or/1/zero, lui lui/1/upper, lw and sw add/1/sign, beq sub/0.
REQ-031 SHALL, in EXEC for beq, set pc_src=1 and pc_we=zero, then go to FETCH.
REQ-032 SHALL, in EXEC for lw/sw, go to MEM; for ALU and mfhi/mflo types, go to WB.
REQ-033 SHALL, in EXEC for mult/div types, pulse md_start, load the countdown with MD_LATENCY, then go to FETCH.
REQ-034 SHALL, in EXEC for mfhi/mflo while busy=1, hold in EXEC with every write enable at 0 until busy falls.
REQ-035 SHALL, on a mult/div in EXEC while busy=1, also hold in EXEC with no new md_start.
REQ-036 SHALL, in MEM, assert mem_we=1 and go to FETCH for sw; for lw, go to WB.
REQ-037 SHALL, in WB, assert reg_we=1 and go to FETCH, with reg_dst: lw 0, ori/lui 0, R-type 1.
REQ-038 SHALL, in WB, drive wd_sel: lw 1, mfhi/mflo 3, others 0.
REQ-039 SHALL make every output a function of the state and the decode only, with no latches.
REQ-040 SHALL drive every enable not asserted by the rules above to 0.
REQ-041 SHALL decrement the countdown by 1 each cycle while it is nonzero, independent of the state, and never let it underflow.
REQ-042 SHALL drive busy as (countdown != 0).

Reset
REQ-043 SHALL, on reset_n=0, immediately force state to FETCH, clear the countdown, and take every output to 0 except state and ir_we/pc_we (the FETCH values).
REQ-044 SHALL abort any in-flight mult/div on reset mid-operation, leaving busy=0.

Structure
REQ-045 SHALL place the opcode/func constants, the state encodings, and the alu_ctrl, pc_src, wd_sel and reg_dst codes in the shared package mips_defs.
REQ-046 SHALL use one sub-module, md_counter (load, decrement, busy), for the mult/div countdown.

Verification
REQ-047 SHALL cover: reset, then addu -> states 0,1,2,4,0, with reg_we=1 and reg_dst=1 only in WB.
REQ-048 SHALL cover: lw -> 5 cycles with wd_sel=1 in WB; sw -> 4 cycles with mem_we=1 only in MEM.
REQ-049 SHALL cover: beq with zero=1 -> pc_we=1, pc_src=1 in EXEC; with zero=0 -> pc_we=0.
REQ-050 SHALL cover: jal -> 2 cycles, reg_dst=2, wd_sel=2, pc_src=2.
REQ-051 SHALL cover: mult then immediate mflo, MD_LATENCY=5 -> busy for 5 cycles, EXEC held until busy=0, then WB with wd_sel=3.
REQ-052 SHALL cover: reset_n pulled low during WB and while busy -> state=0 and busy=0 asynchronously.
